// File: rtl/peripheral_sqrt_gen.sv
// Memory-mapped integer square-root peripheral.
// Restoring digit-by-digit datapath, one root bit per clock. Root/remainder
// registers, sticky done flag, level completion interrupt.
module peripheral_sqrt_gen #(
  parameter int          WIDTH     = 32,
  parameter logic [4:0]  ADDR_A    = 5'h04,
  parameter logic [4:0]  ADDR_CTRL = 5'h0C,
  parameter logic [4:0]  ADDR_RES  = 5'h10,
  parameter logic [4:0]  ADDR_STAT = 5'h14,
  parameter logic [4:0]  ADDR_REM  = 5'h18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out,
  output logic        irq
);

  // H root bits; the partial remainder carries two guard bits so the trial
  // subtraction never loses the borrow information.
  localparam int H  = WIDTH / 2;
  localparam int PW = H + 2;
  localparam int CW = $clog2(H + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  op_q, op_d;      // operand shift register, MSB pair consumed first
  logic [H-1:0]      acc_q, acc_d;    // root under construction
  logic [PW-1:0]     prem_q, prem_d;  // partial remainder
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [H-1:0]      root_q, root_d;
  logic [H:0]        rem_q, rem_d;
  logic              done_q, done_d;
  logic              irq_en_q, irq_en_d;
  logic [31:0]       dout_q, dout_d;

  logic              wr_en, rd_en, busy, start_req;
  logic [PW+1:0]     ext, sub;
  logic [PW-1:0]     diff, prem_step;
  logic [H-1:0]      acc_step;
  logic              ge;
  logic [31:0]       rd_val;

  assign wr_en     = cs & wr;
  assign rd_en     = cs & rd;
  assign busy      = (state_q == S_RUN);
  assign start_req = wr_en && (addr == ADDR_CTRL) && d_in[0];

  // One restoring iteration: bring down the next operand bit pair and try
  // subtracting {root, 01}. The low PW bits of the difference are exact
  // whenever the trial succeeds, so the narrow subtractor is sufficient.
  always_comb begin
    ext       = {prem_q, op_q[WIDTH-1 -: 2]};
    sub       = {2'b00, acc_q, 2'b01};
    ge        = (ext >= sub);
    diff      = ext[PW-1:0] - sub[PW-1:0];
    prem_step = ge ? diff : ext[PW-1:0];
    acc_step  = {acc_q[H-2:0], ge};
  end

  // Register read mux, zero-extended to the bus width.
  always_comb begin
    rd_val = '0;
    if (addr == ADDR_A)         rd_val = 32'(a_q);
    else if (addr == ADDR_CTRL) rd_val = {30'b0, irq_en_q, 1'b0};
    else if (addr == ADDR_RES)  rd_val = 32'(root_q);
    else if (addr == ADDR_STAT) rd_val = {30'b0, busy, done_q};
    else if (addr == ADDR_REM)  rd_val = 32'(rem_q);
  end

  // Next-state: bus writes, sticky done, FSM and datapath step.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    op_d     = op_q;
    acc_d    = acc_q;
    prem_d   = prem_q;
    cnt_d    = cnt_q;
    root_d   = root_q;
    rem_d    = rem_q;
    done_d   = done_q;
    irq_en_d = irq_en_q;
    dout_d   = rd_en ? rd_val : dout_q;

    if (wr_en && (addr == ADDR_A))    a_d      = d_in[WIDTH-1:0];
    if (wr_en && (addr == ADDR_CTRL)) irq_en_d = d_in[1];
    // A status read clears done; a completion on the same edge wins below.
    if (rd_en && (addr == ADDR_STAT)) done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          op_d    = a_q;
          acc_d   = '0;
          prem_d  = '0;
          done_d  = 1'b0;
          cnt_d   = CW'(H);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // start_req is ignored here; the running operation continues.
        op_d   = op_q << 2;
        acc_d  = acc_step;
        prem_d = prem_step;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          root_d  = acc_step;
          rem_d   = prem_step[H:0];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath and register-file state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      prem_q   <= '0;
      cnt_q    <= '0;
      root_q   <= '0;
      rem_q    <= '0;
      done_q   <= 1'b0;
      irq_en_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      a_q      <= a_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      prem_q   <= prem_d;
      cnt_q    <= cnt_d;
      root_q   <= root_d;
      rem_q    <= rem_d;
      done_q   <= done_d;
      irq_en_q <= irq_en_d;
      dout_q   <= dout_d;
    end
  end

  assign d_out = dout_q;
  assign irq   = done_q & irq_en_q;

endmodule
